// File: rtl/toggle_event_rx.sv
// Toggle-signalling receiver: synchronises a remote toggle line, queues
// each level change as an event and returns an acknowledge toggle.
module toggle_event_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int TOTAL_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tgl_in,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic               evt_pulse,
   output logic               ack_tgl,
   output logic [CNT_W-1:0]   pending,
   output logic [TOTAL_W-1:0] total,
   output logic               ovf,
   input  logic               ovf_clr
);

   localparam int AW = $clog2(SYNC_STAGES + 2);
   localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES);

   typedef enum logic {
      ARMING,
      ARMED
   } arm_t;

   arm_t state, state_nx;
   logic [AW-1:0] arm_cnt, arm_cnt_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic sync_out;
   logic prev;
   logic det;
   logic acc;
   logic full;
   logic [CNT_W-1:0] pending_nx;
   logic ovf_nx;

   assign sync_out  = sync[SYNC_STAGES-1];
   assign evt_valid = |pending;
   assign acc       = evt_valid & evt_ready;
   assign full      = &pending;
   assign det       = (state == ARMED) & (sync_out ^ prev);

   // Arming: inhibit detection for the first SYNC_STAGES+1 edges
   always_comb begin
      state_nx   = state;
      arm_cnt_nx = arm_cnt;
      if (state == ARMING) begin
         arm_cnt_nx = arm_cnt + 1'b1;
         if (arm_cnt == ARM_LAST)
            state_nx = ARMED;
      end
   end

   always_comb begin
      pending_nx = pending;
      ovf_nx     = ovf;
      if (det && !acc) begin
         if (full)
            ovf_nx = 1'b1;
         else
            pending_nx = pending + 1'b1;
      end else if (acc && !det) begin
         pending_nx = pending - 1'b1;
      end
      if (!(det && full && !acc) && ovf_clr)
         ovf_nx = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARMING;
         arm_cnt   <= '0;
         sync      <= '0;
         prev      <= 1'b0;
         evt_pulse <= 1'b0;
         ack_tgl   <= 1'b0;
         pending   <= '0;
         total     <= '0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_nx;
         arm_cnt   <= arm_cnt_nx;
         sync      <= {sync[SYNC_STAGES-2:0], tgl_in};
         prev      <= sync_out;
         evt_pulse <= det;
         ack_tgl   <= ack_tgl ^ acc;
         pending   <= pending_nx;
         total     <= total + TOTAL_W'(det);
         ovf       <= ovf_nx;
      end
   end

endmodule

// File: doc/toggle_event_rx.md
Name: toggle_event_rx

Overview:
- Receiving end of a toggle-signalling link. A remote T flip-flop toggles `tgl_in` once per event.
- This block synchronises `tgl_in` and detects each level change as one event. It queues events as a pending count and hands them to a consumer with a valid/ready handshake.
- It returns an acknowledge toggle, `ack_tgl`, to the sender. It also keeps a wrapping total-event count and a sticky overflow flag.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `tgl_in` (min 2).
- CNT_W, 4, width of the pending-event counter. Capacity is 2^CNT_W-1 events.
- TOTAL_W, 16, width of the total-event counter. Wraps modulo 2^TOTAL_W.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tgl_in  in  1  toggle line from the sender. Asynchronous to `clk`. One level change equals one event.
- evt_valid  out  1  high while pending > 0.
- evt_ready  in  1  consumer accepts one event on an edge where `evt_valid` and `evt_ready` are both high.
- evt_pulse  out  1  registered one-cycle strobe per detected toggle, including dropped ones.
- ack_tgl  out  1  toggles once per accepted event (T flip-flop, T = accept).
- pending  out  CNT_W  number of events queued and not yet accepted.
- total  out  TOTAL_W  count of detected toggles, wrapping.
- ovf  out  1  sticky; set when a detected toggle is dropped because the queue is full.
- ovf_clr  in  1  synchronous clear for `ovf`.

Behaviour:
- Reset (asynchronous assert, applies immediately):
  - All outputs go to 0: `evt_valid`, `evt_pulse`, `ack_tgl`, `pending`, `total`, `ovf`.
  - Synchroniser chain, previous-level register and arm counter also go to 0.
- Arming after reset release:
  - Edge detection is inhibited for the first SYNC_STAGES+1 rising edges.
  - During this window the previous-level register follows the synchroniser output every edge, so a `tgl_in` held at 1 through reset produces no event.
  - Arm state machine: ARMING (counter counts to SYNC_STAGES+1), then ARMED. ARMED is left only by reset.
- Detection in ARMED:
  - Condition: `det` = `sync_out` XOR `prev`; `prev` <= `sync_out` on every edge.
  - Latency (SYNC_STAGES=2): a `tgl_in` change set up before edge E1 is detected at edge E3.
  - At E3, `pending`, `total` and `ovf` update, and `evt_pulse` is high from E3 to E4.
  - `tgl_in` must hold each level for at least SYNC_STAGES+1 cycles. Faster toggling may lose events; this is not checked.
- Accept: `acc` = `evt_valid` AND `evt_ready`. When `evt_valid` is low, `evt_ready` is ignored.
- Pending update per edge:
  - `det` and not `acc`: pending+1 if not full; if full, hold and set `ovf`.
  - `acc` and not `det`: pending-1.
  - `det` and `acc`: pending unchanged. This holds even when full, and then no overflow is flagged.
  - Neither: hold.
- `evt_valid` equals (pending != 0) and is derived from the registered count. After an accept that empties the queue, it drops in the same cycle `pending` reaches 0.
- `ack_tgl` inverts on every edge with `acc`. It is unaffected by `det` and by overflow.
- `total` increments on every `det`, including dropped events; it wraps from 2^TOTAL_W-1 to 0.
- `ovf` priority: set on (`det` and full and not `acc`). Otherwise cleared by `ovf_clr`. Set wins over a simultaneous `ovf_clr`.
- Reset mid-operation:
  - Queued events are discarded, `ack_tgl` returns to 0, and arming restarts.
  - The sender must also be reset so both toggle levels restart at 0.

Test Plan:
- Arming: hold `tgl_in`=1 through reset and release, wait 10 cycles → `evt_pulse` never asserts; `pending`=0, `total`=0.
- Latency and accept: after arming, toggle `tgl_in` 0→1 with `evt_ready`=0 → `evt_pulse` high exactly 3 edges later; `pending`=1, `evt_valid`=1. Raise `evt_ready` for one cycle → `pending`=0, `ack_tgl`=1.
- Fill and overflow (CNT_W=4), `evt_ready`=0:
  - 15 toggles spaced 4 cycles apart → `pending`=15, `ovf`=0.
  - 16th toggle → `pending`=15, `ovf`=1, `total`=16.
  - Pulse `ovf_clr` → `ovf`=0.
- Simultaneous event and accept at full: `pending`=15, `evt_ready`=1 on the detection edge → `pending`=15, `ovf`=0, `ack_tgl` toggles.
- Wrap (TOTAL_W=4): 17 toggles with `evt_ready`=1 → `total`=1; `ack_tgl` equals the parity of the accepted count (17 → 1).
- Reset mid-operation: with `pending`=5, `ack_tgl`=1, assert `rst` between edges → all outputs 0 immediately. After release, the first toggle is accepted only after re-arming (SYNC_STAGES+1 edges).
